prog_loader: RTL and testbench

//  Write-side counterpart of the core's instruction fetch. Receives a byte stream over a valid/ready

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader_if.sv | 34 +++
 rtl/prog_loader_word_packer.sv | 58 +++++
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and types for the program loader.
//   PL_ADDR_W   default program address width (PC width)
//   PL_INSTR_W  default instruction width
//   PL_NB       bytes per instruction word, rounded up
//   ld_state_e  loader FSM state encoding (also exported as a debug port)
package prog_loader_pkg;

   // Bytes needed to carry one w-bit word.
   function automatic int nb_bytes(input int w);
      return (w + 7) / 8;
   endfunction

   localparam int PL_ADDR_W  = 8;
   localparam int PL_INSTR_W = 17;
   localparam int PL_NB      = nb_bytes(PL_INSTR_W);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_CNT  = 4'd1,
      ST_B0   = 4'd2,
      ST_B1   = 4'd3,
      ST_B2   = 4'd4,
      ST_WR   = 4'd5,
      ST_CHK  = 4'd6,
      ST_DONE = 4'd7,
      ST_ERR  = 4'd8
   } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host byte stream plus prog_mem write port.
//   in_valid/in_data  host -> loader byte stream
//   in_ready          loader -> host
//   pm_we/addr/wdata  loader -> prog_mem synchronous write port
// Handshake: a byte moves on a rising clock edge where in_valid && in_ready
// are both high; in_data is don't-care otherwise. The host may hold in_valid
// low for any number of cycles. pm_addr/pm_wdata are meaningful only while
// pm_we is high.
// Modports: slave = the loader, master = host / memory side.
interface prog_loader_if
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W  = PL_ADDR_W,
   parameter int INSTR_W = PL_INSTR_W
) ();

   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               pm_we;
   logic [ADDR_W-1:0]  pm_addr;
   logic [INSTR_W-1:0] pm_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, pm_we, pm_addr, pm_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, pm_we, pm_addr, pm_wdata
   );

endinterface

// File: rtl/prog_loader_word_packer.sv
// prog_loader_word_packer: assembles NB little-endian bytes into one word.
//   clk, reset   clock, asynchronous active-high reset
//   clr          restart byte count for a new load
//   shift_en     a payload byte is being accepted this cycle
//   byte_in      the payload byte
//   word_o       word including byte_in (valid on the final byte)
//   pad_err      final byte carries set bits above INSTR_W-1
module prog_loader_word_packer #(
   parameter int NB      = 3,
   parameter int INSTR_W = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               shift_en,
   input  logic [7:0]         byte_in,
   output logic [INSTR_W-1:0] word_o,
   output logic               pad_err
);

   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

   // Only the first NB-1 bytes need storing; the final byte comes straight
   // from byte_in so the word is complete in the cycle it is accepted.
   logic [(NB-1)*8-1:0] acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NB*8-1:0]     word_nxt;
   logic                last;

   assign word_nxt = {byte_in, acc_q};
   assign last     = (cnt_q == LAST_IDX);
   assign word_o   = word_nxt[INSTR_W-1:0];
   assign pad_err  = last && (word_nxt[NB*8-1:INSTR_W] != '0);

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (shift_en) begin
         acc_d = word_nxt[NB*8-1:8];
         cnt_d = last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a byte stream (CNT, CNT words x NB bytes, CHK) into
// prog_mem and holds the core while loading.
//   clk, reset   clock, asynchronous active-high reset
//   start        1-cycle pulse; honoured in IDLE/DONE/ERR
//   bus          byte stream in, prog_mem write port out (slave modport)
//   core_hold    core must not fetch; stays high after a failed load
//   busy         load in progress
//   done / err   outcome of the last load, sticky until the next start
//   dbg_state    current FSM state
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                ADDR_W    = PL_ADDR_W,
   parameter int                INSTR_W   = PL_INSTR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   prog_loader_if.slave   bus,
   output logic           core_hold,
   output logic           busy,
   output logic           done,
   output logic           err,
   output ld_state_e      dbg_state
);

   localparam int NB = nb_bytes(INSTR_W);
   localparam int LW = ADDR_W + 1;
   // CNT = 0 encodes a full image of 2**ADDR_W words.
   localparam logic [LW-1:0] LEFT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [LW-1:0] LEFT_ONE  = LW'(1);

   ld_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  widx_q, widx_d;
   logic [LW-1:0]      left_q, left_d;
   logic [7:0]         csum_q, csum_d;
   logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
   logic [INSTR_W-1:0] pm_wdata_q, pm_wdata_d;
   logic               in_ready_q, in_ready_d;
   logic               pm_we_q, pm_we_d;
   logic               busy_q, busy_d;
   logic               hold_q, hold_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               accept;
   logic               pk_clr, pk_shift;
   logic [INSTR_W-1:0] pk_word;
   logic               pk_pad_err;

   assign accept = bus.in_valid && in_ready_q;

   prog_loader_word_packer #(
      .NB      (NB),
      .INSTR_W (INSTR_W)
   ) u_packer (
      .clk      (clk),
      .reset    (reset),
      .clr      (pk_clr),
      .shift_en (pk_shift),
      .byte_in  (bus.in_data),
      .word_o   (pk_word),
      .pad_err  (pk_pad_err)
   );

   always_comb begin
      state_d    = state_q;
      widx_d     = widx_q;
      left_d     = left_q;
      csum_d     = csum_q;
      pm_addr_d  = pm_addr_q;
      pm_wdata_d = pm_wdata_q;
      pk_clr     = 1'b0;
      pk_shift   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_CNT;
               csum_d  = '0;
               widx_d  = '0;
               left_d  = '0;
               pk_clr  = 1'b1;
            end
         end
         ST_CNT: begin
            if (accept) begin
               csum_d  = csum_q ^ bus.in_data;
               left_d  = (bus.in_data == 8'h00) ? LEFT_FULL : LW'(bus.in_data);
               state_d = ST_B0;
            end
         end
         ST_B0, ST_B1: begin
            if (accept) begin
               csum_d   = csum_q ^ bus.in_data;
               pk_shift = 1'b1;
               state_d  = (state_q == ST_B0) ? ST_B1 : ST_B2;
            end
         end
         ST_B2: begin
            if (accept) begin
               pk_shift = 1'b1;
               if (pk_pad_err) begin
                  state_d = ST_ERR;
               end else begin
                  csum_d     = csum_q ^ bus.in_data;
                  // Loaded here so the registered write port is valid in WR.
                  pm_addr_d  = BASE_ADDR + widx_q;
                  pm_wdata_d = pk_word;
                  state_d    = ST_WR;
               end
            end
         end
         ST_WR: begin
            widx_d  = widx_q + ADDR_W'(1);
            left_d  = left_q - LEFT_ONE;
            state_d = (left_q == LEFT_ONE) ? ST_CHK : ST_B0;
         end
         ST_CHK: begin
            if (accept) begin
               state_d = (csum_q == bus.in_data) ? ST_DONE : ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are a registered decode of the next state.
      in_ready_d = (state_d == ST_CNT) || (state_d == ST_B0) || (state_d == ST_B1) ||
                   (state_d == ST_B2)  || (state_d == ST_CHK);
      pm_we_d    = (state_d == ST_WR);
      busy_d     = in_ready_d || pm_we_d;
      // A failed load keeps the core halted so a partial image never runs.
      hold_d     = busy_d || (state_d == ST_ERR);
      done_d     = (state_d == ST_DONE);
      err_d      = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         widx_q     <= '0;
         left_q     <= '0;
         csum_q     <= '0;
         pm_addr_q  <= BASE_ADDR;
         pm_wdata_q <= '0;
         in_ready_q <= 1'b0;
         pm_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         widx_q     <= widx_d;
         left_q     <= left_d;
         csum_q     <= csum_d;
         pm_addr_q  <= pm_addr_d;
         pm_wdata_q <= pm_wdata_d;
         in_ready_q <= in_ready_d;
         pm_we_q    <= pm_we_d;
         busy_q     <= busy_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.pm_we    = pm_we_q;
   assign bus.pm_addr  = pm_addr_q;
   assign bus.pm_wdata = pm_wdata_q;
   assign core_hold    = hold_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;
   import prog_loader_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(8), .INSTR_W(17)) if0 ();
   prog_loader_if #(.ADDR_W(8), .INSTR_W(17)) if1 ();

   logic hold0, busy0, done0, err0;
   logic hold1, busy1, done1, err1;
   ld_state_e st0, st1;

   prog_loader #(.ADDR_W(8), .INSTR_W(17), .BASE_ADDR(8'h00)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .bus(if0),
      .core_hold(hold0), .busy(busy0), .done(done0), .err(err0), .dbg_state(st0)
   );

   prog_loader #(.ADDR_W(8), .INSTR_W(17), .BASE_ADDR(8'hFE)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .bus(if1),
      .core_hold(hold1), .busy(busy1), .done(done1), .err(err1), .dbg_state(st1)
   );

   // ---------------- scoreboard ----------------
   int tests_run = 0;
   int fail_cnt  = 0;
   int wr_cnt1   = 0;
   logic [24:0] exp_q0[$];   // {addr, data}
   logic [24:0] exp_q1[$];
   logic [24:0] got0, got1, exp0, exp1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: every write strobe must match the head of its expected queue.
   always @(negedge clk) begin
      if (!reset && if0.pm_we) begin
         got0 = {if0.pm_addr, if0.pm_wdata};
         if (exp_q0.size() == 0) begin
            tests_run++;
            fail_cnt++;
            $display("FAIL dut0_write: unexpected write %h, none expected", got0);
         end else begin
            exp0 = exp_q0.pop_front();
            check("dut0_write", {7'd0, got0}, {7'd0, exp0});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && if1.pm_we) begin
         wr_cnt1++;
         got1 = {if1.pm_addr, if1.pm_wdata};
         if (exp_q1.size() == 0) begin
            tests_run++;
            fail_cnt++;
            $display("FAIL dut1_write: unexpected write %h, none expected", got1);
         end else begin
            exp1 = exp_q1.pop_front();
            check("dut1_write", {7'd0, got1}, {7'd0, exp1});
         end
      end
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic start_pulse(input int d);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic send_byte(input int d, input logic [7:0] b);
      int n;
      logic rdy;
      if (d == 0) begin if0.in_valid = 1'b1; if0.in_data = b; end
      else        begin if1.in_valid = 1'b1; if1.in_data = b; end
      rdy = 1'b0;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         rdy = (d == 0) ? if0.in_ready : if1.in_ready;
         if (rdy) break;
      end
      if (!rdy) begin
         tests_run++;
         fail_cnt++;
         $display("FAIL send_byte_timeout: dut%0d in_ready stayed 0, required 1", d);
      end
      @(posedge clk); #1;
      // Junk on the bus while idle must be ignored.
      if (d == 0) begin if0.in_valid = 1'b0; if0.in_data = 8'($urandom_range(0, 255)); end
      else        begin if1.in_valid = 1'b0; if1.in_data = 8'($urandom_range(0, 255)); end
   endtask

   task automatic send_seq(input int d, input logic [7:0] bs[$], input int gap);
      foreach (bs[i]) begin
         send_byte(d, bs[i]);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_end(input int d);
      int n;
      logic fin;
      fin = 1'b0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         fin = (d == 0) ? (done0 | err0) : (done1 | err1);
         if (fin) break;
      end
      if (!fin) begin
         tests_run++;
         fail_cnt++;
         $display("FAIL wait_end_timeout: dut%0d done/err stayed 0, required 1", d);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset0(input string tag);
      check({tag, "_in_ready"}, if0.in_ready, 0);
      check({tag, "_pm_we"},    if0.pm_we, 0);
      check({tag, "_busy"},     busy0, 0);
      check({tag, "_done"},     done0, 0);
      check({tag, "_err"},      err0, 0);
      check({tag, "_hold"},     hold0, 0);
      check({tag, "_pm_addr"},  if0.pm_addr, 8'h00);
      check({tag, "_pm_wdata"}, if0.pm_wdata, 0);
      check({tag, "_state"},    st0, ST_IDLE);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] seq[$];
   logic [7:0] csum;
   logic [7:0] iv;

   initial begin
      if0.in_valid = 1'b0; if0.in_data = 8'h00;
      if1.in_valid = 1'b0; if1.in_data = 8'h00;
      repeat (3) @(negedge clk);

      // Reset values
      check_reset0("rst0");
      check("rst1_pm_addr", if1.pm_addr, 8'hFE);
      check("rst1_hold",    hold1, 0);
      check("rst1_ready",   if1.in_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // 1 word
      start_pulse(0);
      check("t1_busy", busy0, 1);
      check("t1_hold", hold0, 1);
      check("t1_ready", if0.in_ready, 1);
      exp_q0.push_back({8'h00, 17'h11234});
      seq = '{8'h01, 8'h34, 8'h12, 8'h01};
      send_seq(0, seq, 0);
      check("t1_we_latency", if0.pm_we, 1);
      check("t1_ready_in_wr", if0.in_ready, 0);
      send_byte(0, 8'h26);
      wait_end(0);
      check("t1_done", done0, 1);
      check("t1_err", err0, 0);
      check("t1_hold_end", hold0, 0);
      check("t1_busy_end", busy0, 0);
      check("t1_wdata_held", if0.pm_wdata, 17'h11234);
      check("t1_q_empty", exp_q0.size(), 0);

      // 2 words, host stalls, start while busy ignored
      start_pulse(0);
      check("t2_done_cleared", done0, 0);
      exp_q0.push_back({8'h00, 17'h000AA});
      exp_q0.push_back({8'h01, 17'h10055});
      send_byte(0, 8'h02);
      start_pulse(0);
      check("t2_start_ignored", st0, ST_B0);
      seq = '{8'hAA, 8'h00, 8'h00, 8'h55, 8'h00, 8'h01, 8'hFC};
      send_seq(0, seq, 5);
      wait_end(0);
      check("t2_done", done0, 1);
      check("t2_err", err0, 0);
      check("t2_q_empty", exp_q0.size(), 0);

      // Bad checksum
      start_pulse(0);
      exp_q0.push_back({8'h00, 17'h11234});
      seq = '{8'h01, 8'h34, 8'h12, 8'h01, 8'h00};
      send_seq(0, seq, 0);
      wait_end(0);
      check("t3_err", err0, 1);
      check("t3_done", done0, 0);
      check("t3_hold", hold0, 1);
      check("t3_busy", busy0, 0);
      check("t3_q_empty", exp_q0.size(), 0);

      // Padding violation: no write, immediate error
      start_pulse(0);
      check("t4_err_cleared", err0, 0);
      seq = '{8'h01, 8'h00, 8'h00, 8'h02};
      send_seq(0, seq, 0);
      check("t4_err", err0, 1);
      check("t4_pm_we", if0.pm_we, 0);
      check("t4_ready", if0.in_ready, 0);
      check("t4_hold", hold0, 1);
      repeat (3) @(negedge clk);
      check("t4_ready_later", if0.in_ready, 0);
      @(posedge clk); #1;

      // Wrap: BASE_ADDR FE, CNT 3
      start_pulse(1);
      exp_q1.push_back({8'hFE, 17'h12211});
      exp_q1.push_back({8'hFF, 17'h04433});
      exp_q1.push_back({8'h00, 17'h16655});
      seq = '{8'h03, 8'h11, 8'h22, 8'h01, 8'h33, 8'h44, 8'h00, 8'h55, 8'h66, 8'h01, 8'h74};
      send_seq(1, seq, 0);
      wait_end(1);
      check("t5_done", done1, 1);
      check("t5_q_empty", exp_q1.size(), 0);

      // CNT 0: full 256-word image from FE
      wr_cnt1 = 0;
      start_pulse(1);
      csum = 8'h00;
      send_byte(1, 8'h00);
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         exp_q1.push_back({8'(8'hFE + iv), iv[0], ~iv, iv});
         csum = csum ^ iv ^ ~iv ^ {7'd0, iv[0]};
         send_byte(1, iv);
         send_byte(1, ~iv);
         send_byte(1, {7'd0, iv[0]});
      end
      send_byte(1, csum);
      wait_end(1);
      check("t6_done", done1, 1);
      check("t6_write_count", wr_cnt1, 256);
      check("t6_q_empty", exp_q1.size(), 0);

      // Reset after 2nd payload byte, then a clean reload
      start_pulse(0);
      exp_q0.push_back({8'h00, 17'h000AA});
      seq = '{8'h02, 8'hAA, 8'h00};
      send_seq(0, seq, 0);
      reset = 1'b1;
      #1;
      check_reset0("t7_rst");
      exp_q0.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      start_pulse(0);
      exp_q0.push_back({8'h00, 17'h11234});
      seq = '{8'h01, 8'h34, 8'h12, 8'h01, 8'h26};
      send_seq(0, seq, 0);
      wait_end(0);
      check("t7_done", done0, 1);
      check("t7_hold", hold0, 0);
      check("t7_q_empty", exp_q0.size(), 0);

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
